// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences shared memory, ALU, register file and PC.
// Optional build macro ILLEGAL_TRAP_EN adds the TRAP state and the `illegal` output.
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        iOrD,
  output logic        irWe,
  output logic        pcWe,
  output logic [1:0]  pcSrcCtrl,
  output logic        regWe,
  output logic [1:0]  regDstCtrl,
  output logic [1:0]  regDInCtrl,
  output logic        aluBSrcCtrl,
  output logic [2:0]  op,
  output logic [2:0]  state,
  output logic        instrRetired
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE = 4'd0,  CL_LW  = 4'd1,  CL_SW   = 4'd2,  CL_ADDI = 4'd3,
    CL_XORI = 4'd4,  CL_ADD = 4'd5,  CL_SUB  = 4'd6,  CL_SLT  = 4'd7,
    CL_BEQ  = 4'd8,  CL_BNE = 4'd9,  CL_J    = 4'd10, CL_JAL  = 4'd11,
    CL_JR   = 4'd12, CL_ILL = 4'd13
  } cls_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;

  state_t state_r, next_state_s;
  cls_t   class_r, dec_cls_s;

  function automatic cls_t classify(input logic [5:0] opc, input logic [5:0] fn);
    cls_t c;
    case (opc)
      6'b000000: begin
        case (fn)
          6'b100000: c = CL_ADD;
          6'b100010: c = CL_SUB;
          6'b101010: c = CL_SLT;
          6'b001000: c = CL_JR;
          default:   c = CL_ILL;
        endcase
      end
      6'b000010: c = CL_J;
      6'b000011: c = CL_JAL;
      6'b000100: c = CL_BEQ;
      6'b000101: c = CL_BNE;
      6'b001000: c = CL_ADDI;
      6'b001110: c = CL_XORI;
      6'b100011: c = CL_LW;
      6'b101011: c = CL_SW;
      default:   c = CL_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_op(input cls_t c);
    logic [2:0] o;
    case (c)
      CL_XORI: o = OP_XOR;
      CL_SUB:  o = OP_SUB;
      CL_SLT:  o = OP_SLT;
      default: o = OP_ADD;
    endcase
    return o;
  endfunction

  function automatic logic uses_imm(input cls_t c);
    return (c == CL_LW) || (c == CL_SW) || (c == CL_ADDI) || (c == CL_XORI);
  endfunction

  assign dec_cls_s = classify(instr[31:26], instr[5:0]);
  assign state     = state_r;

  // State and instruction-class registers; class is captured only in DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= state_t'(RESET_STATE);
      class_r <= CL_NONE;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        class_r <= dec_cls_s;
      end else begin
        class_r <= class_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH:  next_state_s = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (dec_cls_s)
          CL_LW, CL_SW, CL_ADDI, CL_XORI,
          CL_ADD, CL_SUB, CL_SLT:       next_state_s = S_EXEC;
          CL_BEQ, CL_BNE:               next_state_s = S_BRANCH;
          CL_J, CL_JAL, CL_JR:          next_state_s = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:                      next_state_s = S_TRAP;
`else
          default:                      next_state_s = S_FETCH;
`endif
        endcase
      end
      S_EXEC:   next_state_s = ((class_r == CL_LW) || (class_r == CL_SW)) ? S_MEM : S_WB;
      S_MEM: begin
        if (memReady) begin
          next_state_s = (class_r == CL_SW) ? S_FETCH : S_WB;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB, S_BRANCH, S_JUMP: next_state_s = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   next_state_s = S_TRAP;
`else
      S_TRAP:   next_state_s = S_FETCH;
`endif
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output decode; reset forces every strobe and select to its idle value
  always_comb begin
    memReq       = 1'b0;
    memWe        = 1'b0;
    iOrD         = 1'b0;
    irWe         = 1'b0;
    pcWe         = 1'b0;
    pcSrcCtrl    = 2'd0;
    regWe        = 1'b0;
    regDstCtrl   = 2'd0;
    regDInCtrl   = 2'd0;
    aluBSrcCtrl  = 1'b0;
    op           = OP_ADD;
    instrRetired = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal      = 1'b0;
`endif
    if (!reset) begin
      case (state_r)
        S_FETCH: begin
          memReq = 1'b1;
          irWe   = memReady;
          pcWe   = memReady;
        end
        S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
          instrRetired = (dec_cls_s == CL_ILL);
`endif
        end
        S_EXEC: begin
          aluBSrcCtrl = uses_imm(class_r);
          op          = alu_op(class_r);
        end
        S_MEM: begin
          memReq       = 1'b1;
          iOrD         = 1'b1;
          memWe        = (class_r == CL_SW);
          instrRetired = memReady && (class_r == CL_SW);
        end
        S_WB: begin
          regWe        = 1'b1;
          instrRetired = 1'b1;
          aluBSrcCtrl  = uses_imm(class_r);
          op           = alu_op(class_r);
          regDInCtrl   = (class_r == CL_LW) ? 2'd1 : 2'd0;
          regDstCtrl   = uses_imm(class_r) ? 2'd0 : 2'd1;
        end
        S_BRANCH: begin
          op           = OP_SUB;
          pcSrcCtrl    = 2'd3;
          pcWe         = ((class_r == CL_BEQ) && zero) || ((class_r == CL_BNE) && !zero);
          instrRetired = 1'b1;
        end
        S_JUMP: begin
          pcWe         = 1'b1;
          pcSrcCtrl    = (class_r == CL_JR) ? 2'd2 : 2'd1;
          regWe        = (class_r == CL_JAL);
          regDstCtrl   = (class_r == CL_JAL) ? 2'd2 : 2'd0;
          regDInCtrl   = (class_r == CL_JAL) ? 2'd2 : 2'd0;
          instrRetired = 1'b1;
        end
        S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: begin
          memReq = 1'b0;
        end
      endcase
    end else begin
      memReq = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class cycle by cycle.
// Also covers reset during a memory stall and the unsupported-opcode path (ILLEGAL_TRAP_EN aware).
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        memReady;
  logic        memReq, memWe, iOrD, irWe, pcWe, regWe, aluBSrcCtrl, instrRetired;
  logic [1:0]  pcSrcCtrl, regDstCtrl, regDInCtrl;
  logic [2:0]  op, state;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks_s = 0;
  int errors_s = 0;
  int ret_cnt_r = 0;
  int bad_we_r  = 0;
  logic mon_en  = 1'b0;
  int r0;

  localparam logic [31:0] I_ADDI = 32'h20080005;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090000;
  localparam logic [31:0] I_BNE  = 32'h15090003;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_ADD  = 32'h01095020;
  localparam logic [31:0] I_SUB  = 32'h01095022;
  localparam logic [31:0] I_XORI = 32'h39280005;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .memReady(memReady),
    .memReq(memReq), .memWe(memWe), .iOrD(iOrD), .irWe(irWe), .pcWe(pcWe),
    .pcSrcCtrl(pcSrcCtrl), .regWe(regWe), .regDstCtrl(regDstCtrl),
    .regDInCtrl(regDInCtrl), .aluBSrcCtrl(aluBSrcCtrl), .op(op), .state(state),
    .instrRetired(instrRetired)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count retirements and any completed store while the monitor is armed
  always @(posedge clk) begin
    if (instrRetired) ret_cnt_r <= ret_cnt_r + 1;
    if (mon_en && memWe && memReady) bad_we_r <= bad_we_r + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_s++;
    if (got !== exp) begin
      errors_s++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run FETCH (zero wait) and DECODE for one instruction; returns at the next state's negedge
  task automatic fd(input logic [31:0] ir);
    instr = ir; memReady = 1'b1; #1;
    check("fd_fetch_state", 32'(state), 32'd0);
    check("fd_irWe", 32'(irWe), 32'd1);
    @(negedge clk); #1;
    check("fd_decode_state", 32'(state), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; instr = 32'd0; zero = 1'b0; memReady = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", 32'({memReq, memWe, irWe, pcWe, regWe, instrRetired}), 32'd0);
    check("rst_selects", 32'({pcSrcCtrl, regDstCtrl, regDInCtrl, aluBSrcCtrl, iOrD, op}), 32'd0);

    // ADDI, zero-wait: F, D, E, WB
    @(negedge clk);
    reset = 1'b0; instr = I_ADDI; memReady = 1'b1; r0 = ret_cnt_r; #1;
    check("addi_f_state", 32'(state), 32'd0);
    check("addi_f_mem", 32'({memReq, iOrD, irWe, pcWe, pcSrcCtrl}), 32'b1_0_1_1_00);
    @(negedge clk); #1;
    check("addi_d_state", 32'(state), 32'd1);
    @(negedge clk); #1;
    check("addi_e_state", 32'(state), 32'd2);
    check("addi_e_alu", 32'({aluBSrcCtrl, op}), 32'b1_000);
    @(negedge clk); #1;
    check("addi_wb_state", 32'(state), 32'd4);
    check("addi_wb_ctl", 32'({regWe, regDstCtrl, regDInCtrl, aluBSrcCtrl, op, instrRetired}),
          32'b1_00_00_1_000_1);
    @(negedge clk); #1;
    check("addi_back_fetch", 32'(state), 32'd0);
    check("addi_retired_once", 32'(ret_cnt_r - r0), 32'd1);

    // LW with 2 stall cycles in MEM; IR changes after DECODE must not matter
    fd(I_LW);
    instr = I_ADD; #1;
    check("lw_e_state", 32'(state), 32'd2);
    check("lw_e_alub_held", 32'(aluBSrcCtrl), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memReady = (i == 2); #1;
      check("lw_mem_state", 32'(state), 32'd3);
      check("lw_mem_req", 32'({memReq, iOrD, memWe, instrRetired}), 32'b1_1_0_0);
    end
    @(negedge clk); #1;
    check("lw_wb", 32'({state, regWe, regDInCtrl, regDstCtrl}), 32'b100_1_01_00);
    @(negedge clk); #1;
    check("lw_7cyc_fetch", 32'(state), 32'd0);

    // BNE taken/not-taken, BEQ taken
    fd(I_BNE); zero = 1'b1; #1;
    check("bne_z1", 32'({state, pcWe, pcSrcCtrl, op, aluBSrcCtrl, instrRetired}), 32'b101_0_11_001_0_1);
    @(negedge clk); #1;
    check("bne_back_fetch", 32'(state), 32'd0);
    fd(I_BNE); zero = 1'b0; #1;
    check("bne_z0", 32'({state, pcWe, pcSrcCtrl, op}), 32'b101_1_11_001);
    @(negedge clk);
    fd(I_BEQ); zero = 1'b1; #1;
    check("beq_z1", 32'({state, pcWe, pcSrcCtrl}), 32'b101_1_11);
    @(negedge clk); zero = 1'b0;

    // JAL and JR
    fd(I_JAL); #1;
    check("jal", 32'({state, pcWe, pcSrcCtrl, regWe, regDstCtrl, regDInCtrl, instrRetired}),
          32'b110_1_01_1_10_10_1);
    @(negedge clk);
    fd(I_JR); #1;
    check("jr", 32'({state, pcWe, pcSrcCtrl, regWe}), 32'b110_1_10_0);
    @(negedge clk);

    // R-type SUB and XORI
    fd(I_SUB); #1;
    check("sub_e", 32'({state, aluBSrcCtrl, op}), 32'b010_0_001);
    @(negedge clk); #1;
    check("sub_wb", 32'({state, regWe, regDstCtrl, regDInCtrl, op}), 32'b100_1_01_00_001);
    @(negedge clk);
    fd(I_XORI); #1;
    check("xori_e", 32'({aluBSrcCtrl, op}), 32'b1_010);
    @(negedge clk); #1;
    check("xori_wb", 32'({regWe, regDstCtrl, op}), 32'b1_00_010);
    @(negedge clk);

    // SW zero-wait: retires in MEM
    fd(I_SW); #1;
    check("sw_e_state", 32'(state), 32'd2);
    @(negedge clk); #1;
    check("sw_mem", 32'({state, memReq, iOrD, memWe, instrRetired}), 32'b011_1_1_1_1);
    @(negedge clk); #1;
    check("sw_back_fetch", 32'(state), 32'd0);

    // SW stalled in MEM, then reset
    fd(I_SW);
    @(negedge clk);
    memReady = 1'b0; mon_en = 1'b1; #1;
    check("swr_mem", 32'({state, memReq, memWe}), 32'b011_1_1);
    @(negedge clk);
    reset = 1'b1; #1;
    check("swr_rst_req", 32'({memReq, memWe}), 32'b0_0);
    @(negedge clk); #1;
    check("swr_rst_state", 32'({state, memReq}), 32'b000_0);
    reset = 1'b0; #1;
    check("swr_refetch", 32'({state, memReq, iOrD}), 32'b000_1_0);
    @(negedge clk); #1;
    check("swr_hold_fetch", 32'({state, memReq}), 32'b000_1);
    check("swr_no_store", 32'(bad_we_r), 32'd0);
    mon_en = 1'b0;

    // Unsupported opcode
    r0 = ret_cnt_r;
    fd(I_ILL);
`ifdef ILLEGAL_TRAP_EN
    #1;
    check("ill_trap", 32'({state, illegal, memReq, pcWe, regWe, instrRetired}), 32'b111_1_0_0_0_0);
    @(negedge clk); @(negedge clk); #1;
    check("ill_trap_stuck", 32'({state, illegal}), 32'b111_1);
    check("ill_no_retire", 32'(ret_cnt_r - r0), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    check("ill_after_rst", 32'({state, illegal}), 32'b000_0);
`else
    #1;
    check("ill_nop_fetch", 32'(state), 32'd0);
    check("ill_nop_retired", 32'(ret_cnt_r - r0), 32'd1);
    instr = I_ILL; memReady = 1'b0; #1;
    check("ill_nop_idle", 32'({regWe, memWe}), 32'b0_0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
    $finish;
  end

  // DECODE-cycle view of the unsupported opcode, checked from a separate process
  initial begin
    wait (instr == I_ILL);
    @(negedge clk); #2;
    check("ill_decode_state", 32'(state), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    check("ill_decode_quiet", 32'({instrRetired, regWe, memWe, pcWe}), 32'b0_0_0_0);
`else
    check("ill_decode_retire", 32'({instrRetired, regWe, memWe, pcWe}), 32'b1_0_0_0);
`endif
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM for the multicycle variant of the MIPS-subset core. Sequences a single shared instruction/data memory, ALU, register file and PC over several cycles per instruction. Sits beside the datapath, which holds the IR, PC, ALUOut and MDR registers. Supports LW, SW, J, JAL, BEQ, BNE, XORI, ADDI and R-type ADD, SUB, SLT, JR. Control encodings match the single-cycle decoder.

Parameters:
RESET_STATE, 3'd0, state entered on reset (FETCH). Fixed; exposed only for bench readability.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instr  in  32  IR contents; valid from DECODE onward
zero  in  1  ALU zero flag, combinational from the current operands
memReady  in  1  memory completes the outstanding request this cycle
memReq  out  1  memory request strobe
memWe  out  1  write enable qualifying memReq
iOrD  out  1  memory address select: 0=PC, 1=ALUOut
irWe  out  1  load IR from memory read data
pcWe  out  1  PC write enable
pcSrcCtrl  out  2  0=PC+4, 1=jump target, 2=rs (JR), 3=branch target
regWe  out  1  register file write enable
regDstCtrl  out  2  write address: 0=rt, 1=rd, 2=r31
regDInCtrl  out  2  write data: 0=ALU, 1=MDR, 2=PC (JAL link)
aluBSrcCtrl  out  1  ALU B input: 0=rt register, 1=sign-extended immediate
op  out  3  ALU op: 0 ADD, 1 SUB, 2 XOR, 3 SLT
state  out  3  current state, for debug
instrRetired  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, TRAP=7. State register updates on the rising clk edge.
- Reset: with reset high at an edge, state goes to FETCH and the class register clears. While reset is high, all strobes (memReq, memWe, irWe, pcWe, regWe, instrRetired) are forced to 0. Also during reset: op=ADD, pcSrcCtrl=0, all selects 0.
- Reset mid-operation: a pending memory request is abandoned. memReq is 0 in the reset cycle, and the FETCH request is reissued after reset deasserts.
- Defaults (any signal not listed for a state): strobes 0, op=ADD, pcSrcCtrl=0, selects 0.
- FETCH: memReq=1, iOrD=0. Hold while memReady=0. On the memReady cycle: irWe=1, pcWe=1, pcSrcCtrl=0, then go to DECODE.
- DECODE (1 cycle): classify instr[31:26] and instr[5:0] into a registered class. Next state:
  - LW, SW, ADDI, XORI, R-type ADD/SUB/SLT: go to EXEC.
  - BEQ, BNE: go to BRANCH.
  - J, JAL, R-type JR: go to JUMP.
  - Any other opcode or funct: see Optional Feature.
- EXEC: aluBSrcCtrl=1 for LW/SW/ADDI/XORI, 0 for R-type.
  - op: XOR for XORI, SUB/SLT for R-type SUB/SLT, ADD otherwise.
  - Next state: MEM for LW/SW, WB otherwise.
- MEM: memReq=1, iOrD=1, memWe=1 only for SW. Hold while memReady=0.
  - On memReady, SW goes to FETCH with instrRetired=1; LW goes to WB.
- WB: regWe=1, instrRetired=1, then go to FETCH.
  - LW: regDInCtrl=1, regDstCtrl=0.
  - ADDI/XORI: regDInCtrl=0, regDstCtrl=0.
  - R-type: regDInCtrl=0, regDstCtrl=1.
  - op and aluBSrcCtrl hold their EXEC values.
- BRANCH: op=SUB, aluBSrcCtrl=0, pcSrcCtrl=3.
  - pcWe = zero for BEQ, ~zero for BNE.
  - instrRetired=1, then go to FETCH.
- JUMP: pcWe=1, pcSrcCtrl=1 for J/JAL, 2 for JR.
  - JAL also asserts regWe=1, regDstCtrl=2, regDInCtrl=2. The PC at this point already holds PC+4, so the link value is PC+4.
  - instrRetired=1, then go to FETCH.
- memReq remains asserted, with stable iOrD and memWe, from the first request cycle through the memReady cycle inclusive. memReady is ignored outside FETCH and MEM.
- Zero-wait latencies: LW 5 cycles; SW, R-type, ADDI, XORI 4; branches and jumps 3. Each memReady=0 cycle adds one.
- The class is registered at DECODE, so later changes on instr do not affect the instruction in flight.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - DECODE on an unsupported opcode or funct goes to TRAP.
  - TRAP asserts an extra output `illegal`=1 and drives all strobes 0.
  - TRAP is absorbing until reset.
  - instrRetired is not pulsed.
- Not defined:
  - The `illegal` port does not exist.
  - An unsupported encoding is a NOP: DECODE goes to FETCH with instrRetired=1.
  - No architectural state is written.

Test Plan:
- ADDI 0x20080005, memReady=1 always: states F,D,E,WB; WB cycle has regWe=1, regDstCtrl=0, aluBSrcCtrl=1, op=0; instrRetired once; 4 cycles.
- LW 0x8D090004, memReady low for 2 MEM cycles: memReq=1 and iOrD=1 held for 3 MEM cycles, memWe=0; WB has regDInCtrl=1; 7 cycles total.
- BNE 0x15090003, once with zero=1 and once with zero=0: pcWe=0 then pcWe=1 in BRANCH, pcSrcCtrl=3, op=1.
- JAL 0x0C000010: JUMP cycle has pcWe=1, pcSrcCtrl=1, regWe=1, regDstCtrl=2, regDInCtrl=2.
- Reset asserted during MEM of SW 0xAD090000 with memReady=0: memReq=0 during reset; after release, state=FETCH; no memWe pulse ever observed with memReady=1.
- Opcode 0x3F (0xFC000000): with ILLEGAL_TRAP_EN, state=7, illegal=1, stuck until reset; without it, returns to FETCH after 2 cycles with instrRetired=1 and no regWe/memWe/pcWe beyond fetch.
